// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: LED pattern sequencer sitting in front of the 10-bit LED PIO.
// The CPU programs a small pattern table plus timing through an Avalon-MM
// slave; an Avalon-MM master replays the table into the PIO s1 port. CPU
// direct writes share that port but only while the sequencer is idle.
// Optional macro LEDSEQ_IRQ_EN adds a done interrupt (irq tied low otherwise).
module led_seq_ctrl #(
    parameter int LED_WIDTH    = 10,
    parameter int DEPTH        = 8,
    parameter int PERIOD_WIDTH = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    output logic        irq
);

    localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, DONE} state_t;

    state_t                  state;
    logic [LED_WIDTH-1:0]    pat_table [DEPTH];
    logic                    loop_en;
    logic [PERIOD_WIDTH-1:0] period;
    logic [3:0]              len;
    logic [LED_WIDTH-1:0]    direct;
    logic                    done_flag;
    logic                    coll_flag;
    logic [2:0]              idx;
    logic [PERIOD_WIDTH-1:0] cnt;
    logic                    irq_mask_rd;

    // LEN saturates at the table depth; 0 stays 0 (empty table)
    function automatic logic [3:0] clamp_len(input logic [3:0] v);
        return (v > DEPTH_L) ? DEPTH_L : v;
    endfunction

    // HOLD lasts max(PERIOD,1) cycles, so the counter starts at that minus one
    function automatic logic [PERIOD_WIDTH-1:0] period_reload(input logic [PERIOD_WIDTH-1:0] p);
        return (p == '0) ? '0 : p - PERIOD_WIDTH'(1);
    endfunction

    logic wr, wr_ctrl, wr_period, wr_len, wr_status, wr_direct, wr_table;
    logic busy, start_req, stop_req, start_ok;
    logic step_more, loop_again, enter_done;
    logic [2:0]           idx_next;
    logic [2:0]           load_idx;
    logic [LED_WIDTH-1:0] load_pat;

    assign wr        = s_chipselect & ~s_write_n;
    assign wr_ctrl   = wr && (s_address == 4'd0);
    assign wr_period = wr && (s_address == 4'd1);
    assign wr_len    = wr && (s_address == 4'd2);
    assign wr_status = wr && (s_address == 4'd3);
    assign wr_direct = wr && (s_address == 4'd4);
    assign wr_table  = wr && s_address[3] && ({1'b0, s_address[2:0]} < DEPTH_L);

    assign busy      = (state != IDLE);
    // STOP beats START when both bits are written together
    assign stop_req  = wr_ctrl & s_writedata[1];
    assign start_req = wr_ctrl & s_writedata[0] & ~s_writedata[1];
    assign start_ok  = (state == IDLE) && start_req && (len != 4'd0);

    assign idx_next   = idx + 3'd1;
    assign step_more  = (({1'b0, idx} + 4'd1) < len);
    assign loop_again = loop_en && (len != 4'd0);
    assign enter_done = (state == HOLD) && !stop_req && (cnt == '0) && !step_more && !loop_again;

    // Entry loaded on the way into LOAD: the next step from HOLD, else entry 0
    assign load_idx = ((state == HOLD) && step_more) ? idx_next : 3'd0;
    assign load_pat = pat_table[load_idx[IDX_W-1:0]];

    assign pio_address = 2'b00;

    // Writes wider than the used fields simply drop the upper bits
    logic unused_ok;
    assign unused_ok = ^s_writedata;

    // CPU-writable configuration, DIRECT shadow and pattern table
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loop_en <= 1'b0;
            period  <= '0;
            len     <= '0;
            direct  <= '0;
            for (int i = 0; i < DEPTH; i++) pat_table[i] <= '0;
        end else begin
            if (wr_ctrl)   loop_en <= s_writedata[2];
            if (wr_period) period  <= s_writedata[PERIOD_WIDTH-1:0];
            if (wr_len)    len     <= clamp_len(s_writedata[3:0]);
            if (wr_direct) direct  <= s_writedata[LED_WIDTH-1:0];
            if (wr_table)  pat_table[s_address[IDX_W-1:0]] <= s_writedata[LED_WIDTH-1:0];
        end
    end

    // Sequencer FSM, sticky status flags and the registered PIO master port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            idx            <= '0;
            cnt            <= '0;
            done_flag      <= 1'b0;
            coll_flag      <= 1'b0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
        end else begin
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;

            // Flag setting outranks a simultaneous write-1-to-clear
            if (wr_status && s_writedata[1]) done_flag <= 1'b0;
            if (wr_status && s_writedata[2]) coll_flag <= 1'b0;
            if (wr_direct && busy)           coll_flag <= 1'b1;
            if (enter_done)                  done_flag <= 1'b1;

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state          <= LOAD;
                        idx            <= 3'd0;
                        pio_chipselect <= 1'b1;
                        pio_write_n    <= 1'b0;
                        pio_writedata  <= 32'(load_pat);
                    end else if (wr_direct) begin
                        pio_chipselect <= 1'b1;
                        pio_write_n    <= 1'b0;
                        pio_writedata  <= 32'(s_writedata[LED_WIDTH-1:0]);
                    end
                end
                LOAD: begin
                    if (stop_req) begin
                        state <= IDLE;
                    end else begin
                        state <= HOLD;
                        cnt   <= period_reload(period);
                    end
                end
                HOLD: begin
                    if (stop_req) begin
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - PERIOD_WIDTH'(1);
                    end else if (step_more || loop_again) begin
                        state          <= LOAD;
                        idx            <= load_idx;
                        pio_chipselect <= 1'b1;
                        pio_write_n    <= 1'b0;
                        pio_writedata  <= 32'(load_pat);
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LEDSEQ_IRQ_EN
    logic irq_mask;
    logic irq_q;

    // Done interrupt: level set on entering DONE, cleared by DONE W1C or a new run
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ctrl) irq_mask <= s_writedata[3];
            if ((wr_status && s_writedata[1]) || start_ok) irq_q <= 1'b0;
            if (enter_done && irq_mask) irq_q <= 1'b1;
        end
    end

    assign irq         = irq_q;
    assign irq_mask_rd = irq_mask;
`else
    assign irq         = 1'b0;
    assign irq_mask_rd = 1'b0;
`endif

    // Zero-wait combinational register readback
    always_comb begin
        s_readdata = '0;
        case (s_address)
            4'd0: s_readdata = {28'b0, irq_mask_rd, loop_en, 2'b00};
            4'd1: s_readdata = 32'(period);
            4'd2: s_readdata = {28'b0, len};
            4'd3: s_readdata = {25'b0, idx, 1'b0, coll_flag, done_flag, busy};
            4'd4: s_readdata = 32'(direct);
            default: begin
                if (s_address[3] && ({1'b0, s_address[2:0]} < DEPTH_L))
                    s_readdata = 32'(pat_table[s_address[IDX_W-1:0]]);
            end
        endcase
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl: register map, sequencing, looping, STOP,
// DIRECT arbitration/collision, reset and the optional done interrupt.
module tb_led_seq_ctrl;

`ifdef LEDSEQ_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  s_address;
    logic        s_chipselect;
    logic        s_write_n;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wq_cyc[$];
    logic [31:0] wq_dat[$];

    led_seq_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .s_address      (s_address),
        .s_chipselect   (s_chipselect),
        .s_write_n      (s_write_n),
        .s_writedata    (s_writedata),
        .s_readdata     (s_readdata),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    // Log every PIO write the way the PIO slave would see it (at the clock edge)
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pio_chipselect && !pio_write_n) begin
            wq_cyc.push_back(cyc + 1);
            wq_dat.push_back(pio_writedata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        s_address    = a;
        s_writedata  = d;
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        @(negedge clk);
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        s_address    = a;
        s_chipselect = 1'b1;
        s_write_n    = 1'b1;
        #1;
        d = s_readdata;
        s_chipselect = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        logic [31:0] d;
        int n = 0;
        rd(4'd3, d);
        while (d[0] && n < maxc) begin
            @(negedge clk);
            rd(4'd3, d);
            n++;
        end
        check(tag, {31'b0, d[0]}, 32'd0);
    endtask

    task automatic clear_log();
        wq_cyc.delete();
        wq_dat.delete();
    endtask

    initial begin
        int t_start;
        int n;

        reset_n      = 1'b0;
        s_address    = 4'd0;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
        s_writedata  = 32'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        check("rst_pio_cs", {31'b0, pio_chipselect}, 32'd0);
        check("rst_pio_wn", {31'b0, pio_write_n}, 32'd1);
        check("rst_pio_wd", pio_writedata, 32'd0);
        check("rst_pio_addr", {30'b0, pio_address}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        rd_check("rst_status", 4'd3, 32'd0);
        rd_check("rst_ctrl", 4'd0, 32'd0);

        // Configuration and LEN clamp
        wr(4'd8, 32'h001);
        wr(4'd9, 32'h002);
        wr(4'd10, 32'h004);
        wr(4'd2, 32'h00F);
        rd_check("len_clamp", 4'd2, 32'd8);
        wr(4'd2, 32'd3);
        wr(4'd1, 32'd4);
        rd_check("len_rd", 4'd2, 32'd3);
        rd_check("period_rd", 4'd1, 32'd4);
        rd_check("table2_rd", 4'd10, 32'h004);
        rd_check("unmapped_rd", 4'd6, 32'd0);

        // Single run: three writes spaced PERIOD+1 = 5 cycles
        clear_log();
        wr(4'd0, 32'h1);
        t_start = cyc;
        wait_idle("run_timeout", 100);
        repeat (4) @(negedge clk);
        check("run_nwr", wq_dat.size(), 3);
        if (wq_dat.size() == 3) begin
            check("run_wr0", wq_dat[0], 32'h001);
            check("run_wr1", wq_dat[1], 32'h002);
            check("run_wr2", wq_dat[2], 32'h004);
            check("run_lat", wq_cyc[0] - t_start, 1);
            check("run_gap01", wq_cyc[1] - wq_cyc[0], 5);
            check("run_gap12", wq_cyc[2] - wq_cyc[1], 5);
        end
        rd_check("run_status", 4'd3, 32'h22);
        wr(4'd3, 32'h2);
        rd_check("done_w1c", 4'd3, 32'h20);

        // LOOP run, STOP after the fifth write
        clear_log();
        wr(4'd0, 32'h5);
        n = 0;
        while (wq_dat.size() < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("loop_5wr", wq_dat.size(), 5);
        wr(4'd0, 32'h2);
        repeat (20) @(negedge clk);
        check("loop_nwr", wq_dat.size(), 5);
        if (wq_dat.size() == 5) begin
            check("loop_wr2", wq_dat[2], 32'h004);
            check("loop_wr3", wq_dat[3], 32'h001);
            check("loop_wr4", wq_dat[4], 32'h002);
        end
        rd_check("stop_status", 4'd3, 32'h10);

        // PERIOD=0 behaves as 1; single-entry table
        wr(4'd1, 32'd0);
        wr(4'd2, 32'd1);
        wr(4'd8, 32'h3FF);
        clear_log();
        wr(4'd0, 32'h1);
        t_start = cyc;
        rd_check("p0_busy0", 4'd3, 32'h01);
        repeat (2) @(negedge clk);
        rd_check("p0_done", 4'd3, 32'h03);
        @(negedge clk);
        rd_check("p0_idle", 4'd3, 32'h02);
        check("p0_nwr", wq_dat.size(), 1);
        if (wq_dat.size() == 1) begin
            check("p0_wr", wq_dat[0], 32'h3FF);
            check("p0_lat", wq_cyc[0] - t_start, 1);
        end
        wr(4'd3, 32'h2);

        // DIRECT while idle: one PIO write one cycle later
        clear_log();
        wr(4'd4, 32'h155);
        check("dir_cs", {31'b0, pio_chipselect}, 32'd1);
        check("dir_wn", {31'b0, pio_write_n}, 32'd0);
        check("dir_wd", pio_writedata, 32'h155);
        @(negedge clk);
        check("dir_cs_off", {31'b0, pio_chipselect}, 32'd0);
        check("dir_nwr", wq_dat.size(), 1);
        rd_check("dir_rd", 4'd4, 32'h155);

        // DIRECT while busy: register updates, no PIO write, COLLISION set
        wr(4'd1, 32'd4);
        wr(4'd2, 32'd3);
        clear_log();
        wr(4'd0, 32'h1);
        @(negedge clk);
        wr(4'd4, 32'h0AA);
        wait_idle("coll_timeout", 100);
        repeat (3) @(negedge clk);
        check("coll_nwr", wq_dat.size(), 3);
        if (wq_dat.size() == 3) begin
            check("coll_wr0", wq_dat[0], 32'h3FF);
            check("coll_wr2", wq_dat[2], 32'h004);
        end
        rd_check("coll_status", 4'd3, 32'h26);
        rd_check("coll_direct", 4'd4, 32'h0AA);
        wr(4'd3, 32'h4);
        rd_check("coll_w1c", 4'd3, 32'h22);
        wr(4'd3, 32'h2);

        // START ignored with LEN=0, and START+STOP together does nothing
        wr(4'd2, 32'd0);
        clear_log();
        wr(4'd0, 32'h1);
        rd_check("len0_status", 4'd3, 32'h20);
        wr(4'd2, 32'd3);
        wr(4'd0, 32'h3);
        rd_check("ststp_status", 4'd3, 32'h20);
        repeat (3) @(negedge clk);
        check("ignored_nwr", wq_dat.size(), 0);

        // Done interrupt (tied low without the macro)
        wr(4'd2, 32'd1);
        wr(4'd1, 32'd1);
        wr(4'd0, 32'h9);
        rd_check("irq_mask_rd", 4'd0, IRQ_ON ? 32'h8 : 32'h0);
        wait_idle("irq_timeout", 50);
        check("irq_set", {31'b0, irq}, {31'b0, IRQ_ON});
        rd_check("irq_status", 4'd3, 32'h02);
        wr(4'd3, 32'h2);
        check("irq_clr", {31'b0, irq}, 32'd0);
        rd_check("irq_status_clr", 4'd3, 32'h00);

        // Asynchronous reset in the middle of HOLD
        wr(4'd2, 32'd3);
        wr(4'd1, 32'd4);
        wr(4'd0, 32'h1);
        repeat (2) @(negedge clk);
        rd_check("hold_busy", 4'd3, 32'h01);
        #2;
        reset_n = 1'b0;
        s_address = 4'd3;
        #1;
        check("arst_cs", {31'b0, pio_chipselect}, 32'd0);
        check("arst_wn", {31'b0, pio_write_n}, 32'd1);
        check("arst_status", s_readdata, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rd_check("arst_ctrl", 4'd0, 32'd0);
        rd_check("arst_period", 4'd1, 32'd0);
        rd_check("arst_len", 4'd2, 32'd0);
        rd_check("arst_direct", 4'd4, 32'd0);
        rd_check("arst_tab0", 4'd8, 32'd0);
        rd_check("arst_tab2", 4'd10, 32'd0);
        check("arst_wd", pio_writedata, 32'd0);
        check("arst_irq", {31'b0, irq}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
